// File: rtl/hack_dma_pkg.sv
// Shared types for the Hack data-RAM DMA engine.
package hack_dma_pkg;

  localparam int DMA_DATA_W = 16;

  typedef enum logic {
    DMA_FILL = 1'b0,
    DMA_COPY = 1'b1
  } dma_op_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FILL_WR = 3'd1,
    CP_RD   = 3'd2,
    CP_LAT  = 3'd3,
    CP_WR   = 3'd4,
    DONE    = 3'd5
  } dma_state_e;

endpackage

// File: rtl/hack_ram_dma.sv
// Block fill / block copy engine mastering the Hack data-RAM port.
// Copy moves one word at a time (read, latency, write), strictly ascending,
// so overlapping src<dst ranges propagate the source pattern.
module hack_ram_dma
  import hack_dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_src,
  input  logic [ADDR_WIDTH-1:0] cmd_dst,
  input  logic [ADDR_WIDTH:0]   cmd_len,
  input  logic [15:0]           cmd_fill,
  output logic                  busy,
  output logic                  done,
  input  logic                  mem_gnt,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata
);

  // Longest legal transfer: the whole address space.
  localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

  dma_state_e                state, state_n;
  logic [ADDR_WIDTH-1:0]     src_ptr, dst_ptr;
  logic [ADDR_WIDTH:0]       remaining;
  logic [DMA_DATA_W-1:0]     fill_q, hold_q;
  logic [ADDR_WIDTH:0]       len_clamped;

  assign len_clamped = (cmd_len > MAX_LEN) ? MAX_LEN : cmd_len;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

  // State register; reset aborts straight back to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and memory-port drive; writes only ever qualified by grant.
  always_comb begin
    state_n   = state;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0)                     state_n = DONE;
          else if (dma_op_e'(cmd_op) == DMA_COPY) state_n = CP_RD;
          else                                   state_n = FILL_WR;
        end
      end
      FILL_WR: begin
        mem_addr  = dst_ptr;
        mem_wdata = fill_q;
        mem_we    = mem_gnt;
        if (mem_gnt && remaining == 1) state_n = DONE;
      end
      CP_RD: begin
        mem_addr = src_ptr;
        if (mem_gnt) state_n = CP_LAT;
      end
      CP_LAT: begin
        // Read data returns this cycle regardless of grant.
        mem_addr = src_ptr;
        state_n  = CP_WR;
      end
      CP_WR: begin
        mem_addr  = dst_ptr;
        mem_wdata = hold_q;
        mem_we    = mem_gnt;
        if (mem_gnt) state_n = (remaining == 1) ? DONE : CP_RD;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Pointers, count and data holding registers; advance only on granted cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_q    <= '0;
      hold_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            src_ptr   <= cmd_src;
            dst_ptr   <= cmd_dst;
            remaining <= len_clamped;
            fill_q    <= cmd_fill;
          end
        end
        FILL_WR, CP_WR: begin
          if (mem_gnt) begin
            dst_ptr   <= dst_ptr + 1'b1;
            remaining <= remaining - 1'b1;
          end
        end
        CP_LAT: begin
          hold_q  <= mem_rdata;
          src_ptr <= src_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hack_ram_dma.sv
// Self-checking bench for hack_ram_dma: behavioural RAM, write monitor and
// a word-level reference model of fill/copy over a shadow memory.
module tb_hack_ram_dma;
  import hack_dma_pkg::*;

  localparam int AW    = 14;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_op;
  logic [AW-1:0] cmd_src, cmd_dst;
  logic [AW:0]   cmd_len;
  logic [15:0]   cmd_fill;
  logic          busy, done, mem_gnt, mem_we;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hack_ram_dma #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
    .busy(busy), .done(done),
    .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Data RAM with 1-cycle read latency, plus bench-side init/preload port.
  logic [15:0]   ram     [DEPTH];
  logic [15:0]   ref_mem [DEPTH];
  logic          ram_init = 1'b0;
  logic          pl_we = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [15:0]   pl_data = '0;

  always @(posedge clk) begin
    if (ram_init) for (int i = 0; i < DEPTH; i++) ram[i] <= 16'(i * 37 + 5);
    else if (mem_we) ram[mem_addr] <= mem_wdata;
    else if (pl_we)  ram[pl_addr]  <= pl_data;
    mem_rdata <= ram[mem_addr];
  end

  // Bus monitor, sampled mid-cycle.
  typedef struct { int a; int d; int c; } wr_t;
  wr_t wlog[$];
  wr_t expq[$];
  int cyc = 0, done_cnt = 0, busy_cnt = 0, gnt_viol = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) begin
      if (!mem_gnt) gnt_viol <= gnt_viol + 1;
      wlog.push_back('{int'(mem_addr), int'(mem_wdata), cyc});
    end
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  // Grant driver: always granted, or coin-flip per cycle.
  int gnt_mode = 0;
  initial begin
    mem_gnt = 1'b1;
    forever begin
      @(posedge clk); #1;
      mem_gnt = (gnt_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end
  end

  // Reference model: apply a command word by word to the shadow memory.
  task automatic ref_cmd(input bit op, input int src, input int dst, input int len, input int fill);
    int n, a, d;
    n = (len > DEPTH) ? DEPTH : len;
    expq.delete();
    for (int i = 0; i < n; i++) begin
      a = (dst + i) % DEPTH;
      d = op ? int'(ref_mem[(src + i) % DEPTH]) : (fill & 16'hFFFF);
      ref_mem[a] = 16'(d);
      expq.push_back('{a, d, 0});
    end
  endtask

  function automatic int ram_diffs();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (ram[i] !== ref_mem[i]) n++;
    return n;
  endfunction

  function automatic int log_diffs();
    int n = 0;
    if (wlog.size() != expq.size()) return 1 + wlog.size() + expq.size();
    foreach (expq[i]) if (wlog[i].a != expq[i].a || wlog[i].d != expq[i].d) n++;
    return n;
  endfunction

  task automatic preload(input int addr, input int data);
    @(posedge clk); #1;
    pl_we = 1'b1; pl_addr = AW'(addr); pl_data = 16'(data);
    @(posedge clk); #1;
    pl_we = 1'b0;
    ref_mem[addr] = 16'(data);
  endtask

  // Issue one command and wait (bounded) for its done pulse.
  task automatic run_cmd(input bit op, input int src, input int dst, input int len, input int fill,
                         output int busy_cyc, output int ndone, output bit done_early);
    int b0, d0, t;
    wlog.delete();
    b0 = busy_cnt; d0 = done_cnt;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_src = AW'(src); cmd_dst = AW'(dst);
    cmd_len = (AW+1)'(len); cmd_fill = 16'(fill);
    @(posedge clk); #1;
    done_early = done;
    // Garbage on the command bus while busy must be ignored.
    cmd_src = AW'($urandom); cmd_dst = AW'($urandom); cmd_fill = 16'($urandom);
    cmd_len = (AW+1)'($urandom); cmd_op = 1'($urandom);
    cmd_valid = 1'b0;
    t = 0;
    while (done_cnt == d0 && t < 20000) begin @(posedge clk); t++; end
    repeat (3) @(posedge clk);
    busy_cyc = busy_cnt - b0;
    ndone = done_cnt - d0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0;
    cmd_len = '0; cmd_fill = '0;
    ram_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 16'(i * 37 + 5);
    @(posedge clk); #1;
    ram_init = 1'b0;
    @(posedge clk); #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0)      begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we got=%b want=0", mem_we); end
    checks++; if (mem_addr !== '0)    begin errors++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
    checks++; if (mem_wdata !== '0)   begin errors++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_fill();
    int bc, nd; bit de;
    ref_cmd(0, 0, 'h0100, 4, 'hBEEF);
    run_cmd(0, 0, 'h0100, 4, 'hBEEF, bc, nd, de);
    checks++; if (log_diffs() != 0) begin errors++; $display("FAIL fill_writes got=%0d writes want=4 matching", wlog.size()); end
    for (int i = 1; i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].c != wlog[0].c + i) begin errors++; $display("FAIL fill_back_to_back idx=%0d got_cyc=%0d want=%0d", i, wlog[i].c, wlog[0].c + i); end
    end
    checks++; if (bc != 4)  begin errors++; $display("FAIL fill_busy_cycles got=%0d want=4", bc); end
    checks++; if (nd != 1)  begin errors++; $display("FAIL fill_done_pulses got=%0d want=1", nd); end
    checks++; if (de !== 1'b0) begin errors++; $display("FAIL fill_done_early got=%b want=0", de); end
    checks++; if (ram['h0103] !== 16'hBEEF) begin errors++; $display("FAIL fill_readback got=%h want=beef", ram['h0103]); end
    checks++; if (ram_diffs() != 0) begin errors++; $display("FAIL fill_ram got=%0d diffs want=0", ram_diffs()); end
  endtask

  task automatic test_copy();
    int bc, nd; bit de;
    preload('h0010, 'h1111); preload('h0011, 'h2222); preload('h0012, 'h3333);
    ref_cmd(1, 'h0010, 'h0200, 3, 0);
    run_cmd(1, 'h0010, 'h0200, 3, 0, bc, nd, de);
    checks++; if (log_diffs() != 0) begin errors++; $display("FAIL copy_writes got=%0d writes want=3 matching", wlog.size()); end
    checks++; if (bc != 9) begin errors++; $display("FAIL copy_busy_cycles got=%0d want=9", bc); end
    checks++; if (nd != 1) begin errors++; $display("FAIL copy_done_pulses got=%0d want=1", nd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL copy_busy_after got=%b want=0", busy); end
    checks++; if (ram['h0202] !== 16'h3333) begin errors++; $display("FAIL copy_readback got=%h want=3333", ram['h0202]); end
    checks++; if (ram_diffs() != 0) begin errors++; $display("FAIL copy_ram got=%0d diffs want=0", ram_diffs()); end
  endtask

  task automatic test_wrap();
    int bc, nd; bit de;
    int want_a[4] = '{'h3FFE, 'h3FFF, 'h0000, 'h0001};
    ref_cmd(0, 0, 'h3FFE, 4, 'h00FF);
    run_cmd(0, 0, 'h3FFE, 4, 'h00FF, bc, nd, de);
    checks++; if (wlog.size() != 4) begin errors++; $display("FAIL wrap_count got=%0d want=4", wlog.size()); end
    for (int i = 0; i < 4 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i].a != want_a[i]) begin errors++; $display("FAIL wrap_addr idx=%0d got=%h want=%h", i, wlog[i].a, want_a[i]); end
    end
    checks++; if (ram_diffs() != 0) begin errors++; $display("FAIL wrap_ram got=%0d diffs want=0", ram_diffs()); end
  endtask

  task automatic test_gnt_drop();
    int bc, nd, v0; bit de;
    v0 = gnt_viol;
    gnt_mode = 1;
    preload('h0400, 'hC0DE); preload('h0401, 'hF00D);
    ref_cmd(1, 'h0400, 'h0500, 2, 0);
    run_cmd(1, 'h0400, 'h0500, 2, 0, bc, nd, de);
    gnt_mode = 0;
    checks++; if (wlog.size() != 2) begin errors++; $display("FAIL gnt_write_count got=%0d want=2", wlog.size()); end
    checks++; if (log_diffs() != 0) begin errors++; $display("FAIL gnt_write_data got=%0d diffs want=0", log_diffs()); end
    checks++; if (gnt_viol != v0) begin errors++; $display("FAIL gnt_we_without_gnt got=%0d want=0", gnt_viol - v0); end
    checks++; if (ram_diffs() != 0) begin errors++; $display("FAIL gnt_ram got=%0d diffs want=0", ram_diffs()); end
  endtask

  task automatic test_overlap();
    int bc, nd; bit de;
    preload('h0020, 'hAAAA);
    ref_cmd(1, 'h0020, 'h0021, 3, 0);
    run_cmd(1, 'h0020, 'h0021, 3, 0, bc, nd, de);
    for (int a = 'h21; a <= 'h23; a++) begin
      checks++;
      if (ram[a] !== 16'hAAAA) begin errors++; $display("FAIL overlap_word addr=%h got=%h want=aaaa", a, ram[a]); end
    end
    checks++; if (ram_diffs() != 0) begin errors++; $display("FAIL overlap_ram got=%0d diffs want=0", ram_diffs()); end
  endtask

  task automatic test_reset_mid();
    int d0, t;
    wlog.delete();
    d0 = done_cnt;
    ref_cmd(0, 0, 'h1000, 10, 'h5A5A);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_dst = AW'('h1000); cmd_len = (AW+1)'(100); cmd_fill = 16'h5A5A;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    t = 0;
    while (wlog.size() < 10 && t < 200) begin @(posedge clk); t++; end
    #1 rst = 1'b1;
    #1;
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL rstmid_mem_we got=%b want=0", mem_we); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_cmd_ready got=%b want=1", cmd_ready); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    checks++; if (done_cnt != d0)     begin errors++; $display("FAIL rstmid_done got=%0d pulses want=0", done_cnt - d0); end
    checks++; if (wlog.size() != 10)  begin errors++; $display("FAIL rstmid_writes got=%0d want=10", wlog.size()); end
    checks++; if (ram_diffs() != 0)   begin errors++; $display("FAIL rstmid_ram got=%0d diffs want=0", ram_diffs()); end
  endtask

  task automatic test_zero_len();
    int bc, nd; bit de;
    expq.delete();
    run_cmd(0, 0, 'h0700, 0, 'h1234, bc, nd, de);
    checks++; if (de !== 1'b1)       begin errors++; $display("FAIL zero_done_timing got=%b want=1", de); end
    checks++; if (nd != 1)           begin errors++; $display("FAIL zero_done_pulses got=%0d want=1", nd); end
    checks++; if (wlog.size() != 0)  begin errors++; $display("FAIL zero_writes got=%0d want=0", wlog.size()); end
    checks++; if (bc != 0)           begin errors++; $display("FAIL zero_busy got=%0d want=0", bc); end
  endtask

  task automatic test_clamp();
    int bc, nd; bit de;
    ref_cmd(0, 0, 'h2345, 'h7FFF, 'h0F0F);
    run_cmd(0, 0, 'h2345, 'h7FFF, 'h0F0F, bc, nd, de);
    checks++; if (wlog.size() != DEPTH) begin errors++; $display("FAIL clamp_writes got=%0d want=%0d", wlog.size(), DEPTH); end
    checks++; if (nd != 1)              begin errors++; $display("FAIL clamp_done got=%0d want=1", nd); end
    checks++; if (ram_diffs() != 0)     begin errors++; $display("FAIL clamp_ram got=%0d diffs want=0", ram_diffs()); end
  endtask

  task automatic test_random();
    int bc, nd, v0, op, src, dst, len; bit de;
    for (int k = 0; k < 12; k++) begin
      op  = $urandom_range(0, 1);
      src = $urandom_range(0, DEPTH - 1);
      dst = (k % 3 == 0) ? (src + $urandom_range(1, 5)) % DEPTH : $urandom_range(0, DEPTH - 1);
      len = $urandom_range(1, 40);
      gnt_mode = $urandom_range(0, 1);
      v0 = gnt_viol;
      ref_cmd(op[0], src, dst, len, $urandom);
      run_cmd(op[0], src, dst, len, expq[0].d, bc, nd, de);
      gnt_mode = 0;
      checks++;
      if (log_diffs() != 0 || nd != 1 || gnt_viol != v0 || ram_diffs() != 0) begin
        errors++;
        $display("FAIL random_cmd k=%0d op=%0d len=%0d got writes=%0d done=%0d viol=%0d ramdiff=%0d want writes=%0d done=1 viol=0 ramdiff=0",
                 k, op, len, wlog.size(), nd, gnt_viol - v0, ram_diffs(), expq.size());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_copy();
    test_wrap();
    test_gnt_drop();
    test_overlap();
    test_reset_mid();
    test_zero_len();
    test_random();
    test_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
